// File: rtl/ahfp_add_mc.sv
// ahfp_add_mc: multi-cycle IEEE-754 single-precision adder with start/done handshake
module ahfp_add_mc (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state;
    logic [31:0] op_a, op_b, spec_val;
    logic spec, sgn, sub, zs;
    logic signed [9:0] exp_r;
    logic [26:0] mb, ms, mn;
    logic [27:0] sum;
    logic [7:0] ea, eb, al_d;
    logic [22:0] fa, fb;
    logic za, zb, ia, ib, na, nb, a_big, al_spec;
    logic [26:0] xa, xb, al_small, al_sh;
    logic [53:0] al_ext;
    logic [31:0] al_val;
    logic [27:0] sum_n;
    logic [4:0] lz;
    logic [26:0] nm_m;
    logic signed [9:0] nm_e, re;
    logic rup;
    logic [24:0] rm;
    logic [31:0] rd_val;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    // unpack, flush denormals, order by magnitude and align the smaller operand with sticky collection
    always_comb begin
        ea = op_a[30:23];
        eb = op_b[30:23];
        fa = op_a[22:0];
        fb = op_b[22:0];
        za = ea == 8'd0;
        zb = eb == 8'd0;
        ia = ea == 8'hFF && fa == 23'd0;
        ib = eb == 8'hFF && fb == 23'd0;
        na = ea == 8'hFF && fa != 23'd0;
        nb = eb == 8'hFF && fb != 23'd0;
        xa = za ? 27'd0 : {1'b1, fa, 3'b000};
        xb = zb ? 27'd0 : {1'b1, fb, 3'b000};
        a_big = {ea, fa} >= {eb, fb};
        al_small = a_big ? xb : xa;
        al_d = a_big ? ea - eb : eb - ea;
        al_ext = {al_small, 27'd0} >> (al_d > 8'd27 ? 8'd27 : al_d);
        al_sh = al_ext[53:27] | {26'd0, |al_ext[26:0]};
        al_spec = na | nb | ia | ib;
        al_val = (na | nb | (ia & ib & (op_a[31] ^ op_b[31]))) ? 32'h7FC00000 :
                 ia ? {op_a[31], 8'hFF, 23'd0} : {op_b[31], 8'hFF, 23'd0};
    end

    // magnitude add or subtract; ordering guarantees a non-negative difference
    always_comb begin
        sum_n = sub ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
    end

    // normalise: right by one on carry-out, otherwise left by the leading-zero count
    always_comb begin
        lz = lzc27(sum[26:0]);
        nm_m = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << lz;
        nm_e = sum[27] ? exp_r + 10'sd1 : exp_r - $signed({5'd0, lz});
    end

    // round to nearest even, renormalise on carry, then resolve specials, zero, underflow and overflow
    always_comb begin
        rup = mn[2] & (mn[3] | mn[1] | mn[0]);
        rm = {1'b0, mn[26:3]} + {24'd0, rup};
        re = rm[24] ? exp_r + 10'sd1 : exp_r;
        rd_val = spec ? spec_val :
                 zs ? {sgn & ~sub, 31'd0} :
                 (exp_r <= 10'sd0) ? {sgn, 31'd0} :
                 (re >= 10'sd255) ? {sgn, 8'hFF, 23'd0} :
                 {sgn, re[7:0], rm[24] ? rm[23:1] : rm[22:0]};
    end

    // control FSM and pipeline registers; everything freezes while clk_en is low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            done <= 1'b0;
            result <= 32'd0;
            op_a <= 32'd0;
            op_b <= 32'd0;
            spec_val <= 32'd0;
            spec <= 1'b0;
            sgn <= 1'b0;
            sub <= 1'b0;
            zs <= 1'b0;
            exp_r <= 10'sd0;
            mb <= 27'd0;
            ms <= 27'd0;
            mn <= 27'd0;
            sum <= 28'd0;
        end else if (clk_en) begin
            done <= state == ROUND;
            case (state)
                IDLE: if (start) begin
                    op_a <= dataa;
                    op_b <= datab;
                    state <= ALIGN;
                end
                ALIGN: begin
                    mb <= a_big ? xa : xb;
                    ms <= al_sh;
                    exp_r <= $signed({2'b00, a_big ? ea : eb});
                    sgn <= a_big ? op_a[31] : op_b[31];
                    sub <= op_a[31] ^ op_b[31];
                    spec <= al_spec;
                    spec_val <= al_val;
                    state <= ADD;
                end
                ADD: begin
                    sum <= sum_n;
                    state <= NORM;
                end
                NORM: begin
                    mn <= nm_m;
                    exp_r <= nm_e;
                    zs <= sum == 28'd0;
                    state <= ROUND;
                end
                ROUND: begin
                    result <= rd_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahfp_add_mc.sv
// tb_ahfp_add_mc: directed checks of the multi-cycle float adder and its handshake
module tb_ahfp_add_mc;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_en = 1'b1;
    logic start = 1'b0;
    logic [31:0] dataa = 32'd0;
    logic [31:0] datab = 32'd0;
    logic done;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;

    ahfp_add_mc dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .start(start),
        .dataa(dataa),
        .datab(datab),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        dataa = a;
        datab = b;
        @(negedge clk);
        start = 1'b0;
        dataa = ~a;
        datab = ~b;
    endtask

    task automatic wait_done(inout int n);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int n = 0;
        issue(a, b);
        chk({tag, "_busy"}, 32'(done), 32'd0);
        wait_done(n);
        chk({tag, "_lat"}, n, 32'd4);
        chk(tag, result, expv);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        reset_n = 1'b1;

        op("add_1_2", 32'h3F800000, 32'h40000000, 32'h40400000);
        op("mix_a", 32'h40400000, 32'hC0600000, 32'hBF000000);
        op("mix_b", 32'h43FA0000, 32'hC1133333, 32'h43F56666);
        op("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
        op("tie_even", 32'h4B800000, 32'h3F800000, 32'h4B800000);
        op("round_up", 32'h4B800000, 32'h40400000, 32'h4B800002);
        op("round_sub", 32'h3F8E363B, 32'hBAA137F4, 32'h3F8E0DED);
        op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        op("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        op("denorm", 32'h00000001, 32'h00000000, 32'h00000000);
        op("neg_zeros", 32'h80000000, 32'h80000000, 32'h80000000);
        op("inf_fin", 32'hFF800000, 32'h3F800000, 32'hFF800000);

        issue(32'h3F800000, 32'h40000000);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_nodone", pulses, 32'd0);

        issue(32'h3F800000, 32'h40000000);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        n = 4;
        wait_done(n);
        chk("stall_lat", n, 32'd7);
        chk("stall_result", result, 32'h40400000);
        clk_en = 1'b0;
        @(negedge clk);
        chk("stall_done_hold", 32'(done), 32'd1);
        clk_en = 1'b1;
        @(negedge clk);
        chk("stall_done_drop", 32'(done), 32'd0);

        issue(32'h4B800000, 32'h40400000);
        @(negedge clk);
        start = 1'b1;
        dataa = 32'h3F800000;
        datab = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        wait_done(n);
        chk("busy_lat", n, 32'd4);
        chk("busy_result", result, 32'h4B800002);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("busy_ignored", pulses, 32'd0);

        issue(32'h40400000, 32'hC0600000);
        n = 0;
        wait_done(n);
        chk("b2b_first_lat", n, 32'd4);
        chk("b2b_first", result, 32'hBF000000);
        start = 1'b1;
        dataa = 32'h3F800000;
        datab = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        dataa = 32'd0;
        datab = 32'd0;
        n = 0;
        while (!done && n < 30) begin
            chk("b2b_hold", result, 32'hBF000000);
            @(negedge clk);
            n++;
        end
        chk("b2b_second_lat", n, 32'd4);
        chk("b2b_second", result, 32'h40400000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahfp_add_mc.md
Name: ahfp_add_mc

Overview:
- Multi-cycle IEEE-754 single-precision adder: result = dataa + datab.
- Sequential counterpart to the combinational subtractor path; exposes the Nios II multi-cycle custom-instruction handshake (start/done, clk_en).
- Sits on the CPU custom-instruction port. Software performs subtraction by flipping bit 31 of datab before issue.

Parameters:
- LATENCY, 4, clock edges from the accepting start edge to the edge that raises done; fixed and not tunable. Used for bench checks only.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- clk_en  in  1  global stall; when low, all state, including done and result, holds.
- start  in  1  request; sampled only in IDLE with clk_en=1.
- dataa  in  32  operand A, IEEE-754 single.
- datab  in  32  operand B, IEEE-754 single.
- done  out  1  one-cycle pulse; result is valid while done=1.
- result  out  32  sum; holds its value until the next completion.

Behaviour:
- Reset: reset_n=0 at a rising edge forces state=IDLE, done=0, result=32'h0 and clears all internal registers. Reset has priority over clk_en and start.
- Reset mid-operation aborts the operation; no done is produced for it.
- Operands are captured on the start edge. Later changes to dataa/datab do not affect the operation in flight.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE. Each transition occurs only on an edge where clk_en=1.
  - IDLE: start=1 captures operands and moves to ALIGN.
  - ALIGN: unpack operands, order them by magnitude, right-shift the smaller mantissa by the exponent difference. Shifted-out bits collect into guard/round/sticky. An exponent difference >= 26 leaves only sticky.
  - ADD: add or subtract 27-bit {hidden,23 mantissa,G,R,S} values according to the sign XOR. Result sign is the larger operand's sign.
  - NORM: on carry-out, shift right 1 and increment exponent (sticky ORed). Otherwise use a single-cycle leading-zero count to shift left and decrement exponent.
  - ROUND: round to nearest, ties to even. A rounding carry renormalises. Pack and register result; done=1 on this edge.
- done is high for exactly one cycle: it rises on the 4th enabled edge after the start edge.
- If clk_en=0 while done=1, done stays high until the next enabled edge.
- start while not in IDLE is ignored; it is not queued.
- Back-to-back: start sampled high in the cycle where done=1 (state is IDLE) is accepted. The next done then follows 4 edges later.
- Special cases are resolved in ALIGN and carried through the pipeline; latency is unchanged.
  - Denormal inputs are treated as signed zero (flush-to-zero).
  - Any NaN input, or +inf + -inf, gives 32'h7FC00000.
  - inf + finite gives that inf. inf + inf of the same sign gives that inf.
  - Exact zero sum gives +0 (32'h00000000). Exception: (-0)+(-0) gives 32'h80000000.
  - Exponent overflow after rounding gives signed inf (exp=FF, mantissa=0).
  - Exponent underflow (biased exponent <= 0 after NORM) gives signed zero.
- Width rules: exponent arithmetic is carried in 10-bit signed so underflow is detectable. The mantissa datapath is 27 bits plus 1 carry bit.

Test Plan:
- Reset: hold reset_n=0 for 2 edges during an active operation -> done=0, result=00000000, and no done pulse follows.
- Basic add: 3F800000+40000000 -> result=40400000, done exactly 4 edges after start.
- Mixed signs: 40400000+C0600000 -> BF000000. 43FA0000+C1133333 -> 43F56666. 3F800000+BF800000 -> 00000000.
- Rounding/ties: 4B800000+3F800000 -> 4B800000 (tie to even). 4B800000+40400000 -> 4B800002. 3F8E363B+BAA137F4 -> 3F8E0DED.
- Specials: 7F7FFFFF+7F7FFFFF -> 7F800000. 7F800000+FF800000 -> 7FC00000. 7FC00000+3F800000 -> 7FC00000. 00000001+00000000 -> 00000000.
- Handshake: drop clk_en for 3 cycles mid-operation -> done is delayed by exactly 3 cycles. Pulse start while busy -> ignored. Assert start in the done cycle -> second result arrives 4 edges later and the first result holds in between.
